grf_scoreboard: RTL and testbench

//  Read-side hazard tracker for the general register file. It records which registers

---
 rtl/grf_scoreboard.sv | 110 +++++++++++
 tb/tb_grf_scoreboard.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/grf_scoreboard.sv
// Register-file hazard scoreboard: tracks in-flight writes per register and how many
// cycles remain until each result can be forwarded. It drives decode stall and forward selects.
module grf_scoreboard #(
    parameter int NREG  = 32,
    parameter int TAG_W = 3,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [1:0]       issue_rs_use,
    input  logic [4:0]       issue_rt,
    input  logic [1:0]       issue_rt_use,
    input  logic             issue_we,
    input  logic [4:0]       issue_wa,
    input  logic [CNT_W-1:0] issue_tnew,
    input  logic             wb_valid,
    input  logic [4:0]       wb_wa,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic             flush,
    output logic             stall,
    output logic [TAG_W-1:0] issue_tag,
    output logic             fwd_rs,
    output logic             fwd_rt
);

    // Compare width covers both the countdown and the 2-bit Tuse.
    localparam int CMP_W = (CNT_W > 2) ? CNT_W : 2;

    logic             pend_q [NREG];
    logic             pend_d [NREG];
    logic [CNT_W-1:0] cnt_q  [NREG];
    logic [CNT_W-1:0] cnt_d  [NREG];
    logic [TAG_W-1:0] tag_q  [NREG];
    logic [TAG_W-1:0] tag_d  [NREG];
    logic [TAG_W-1:0] next_tag_q, next_tag_d;

    logic             rs_pend, rt_pend;
    logic [CMP_W-1:0] rs_cnt, rt_cnt;
    logic             hazard_rs, hazard_rt;
    logic             accept, wb_hit;

    assign rs_pend   = (issue_rs != 5'd0) && pend_q[issue_rs];
    assign rt_pend   = (issue_rt != 5'd0) && pend_q[issue_rt];
    assign rs_cnt    = CMP_W'(cnt_q[issue_rs]);
    assign rt_cnt    = CMP_W'(cnt_q[issue_rt]);
    assign hazard_rs = rs_pend && (rs_cnt > CMP_W'(issue_rs_use));
    assign hazard_rt = rt_pend && (rt_cnt > CMP_W'(issue_rt_use));

    assign stall     = issue_valid && (hazard_rs || hazard_rt);
    assign fwd_rs    = rs_pend && (rs_cnt == '0);
    assign fwd_rt    = rt_pend && (rt_cnt == '0);
    assign issue_tag = next_tag_q;

    assign accept    = issue_valid && !stall && !flush;
    // A stale tag means a newer write has superseded this one, so it must not clear the entry.
    assign wb_hit    = wb_valid && (wb_wa != 5'd0) && pend_q[wb_wa] && (tag_q[wb_wa] == wb_tag);

    always_comb begin
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        tag_d      = tag_q;
        next_tag_d = next_tag_q;

        for (int r = 0; r < NREG; r++) begin
            if (pend_q[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end

        if (flush) begin
            for (int r = 0; r < NREG; r++) begin
                pend_d[r] = 1'b0;
                cnt_d[r]  = '0;
            end
        end else begin
            if (wb_hit) begin
                pend_d[wb_wa] = 1'b0;
                cnt_d[wb_wa]  = '0;
            end
            // Applied after write-back so a same-register issue takes precedence.
            if (accept && issue_we && (issue_wa != 5'd0)) begin
                pend_d[issue_wa] = 1'b1;
                cnt_d[issue_wa]  = issue_tnew;
                tag_d[issue_wa]  = next_tag_q;
            end
            if (accept) begin
                next_tag_d = next_tag_q + TAG_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= 1'b0;
                cnt_q[r]  <= '0;
                tag_q[r]  <= '0;
            end
            next_tag_q <= '0;
        end else begin
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            tag_q      <= tag_d;
            next_tag_q <= next_tag_d;
        end
    end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard: directed scenarios plus random traffic, checked against
// a model that tracks each write by its absolute ready cycle.
module tb_grf_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic       issue_valid;
    logic [4:0] issue_rs, issue_rt, issue_wa, wb_wa;
    logic [1:0] issue_rs_use, issue_rt_use, issue_tnew;
    logic       issue_we, wb_valid, flush;
    logic [2:0] wb_tag;
    logic       stall, fwd_rs, fwd_rt;
    logic [2:0] issue_tag;

    always #5 clk = ~clk;

    grf_scoreboard dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_rs     (issue_rs),
        .issue_rs_use (issue_rs_use),
        .issue_rt     (issue_rt),
        .issue_rt_use (issue_rt_use),
        .issue_we     (issue_we),
        .issue_wa     (issue_wa),
        .issue_tnew   (issue_tnew),
        .wb_valid     (wb_valid),
        .wb_wa        (wb_wa),
        .wb_tag       (wb_tag),
        .flush        (flush),
        .stall        (stall),
        .issue_tag    (issue_tag),
        .fwd_rs       (fwd_rs),
        .fwd_rt       (fwd_rt)
    );

    typedef struct {
        bit stall;
        bit fr;
        bit ft;
        int tag;
        int cyc;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   now      = 0;

    // Model: a pending write becomes forwardable at absolute cycle m_ready[r].
    bit m_pend [32];
    int m_ready[32];
    int m_tag  [32];
    int m_next;

    function automatic int m_cnt(int r);
        return (m_ready[r] > now) ? (m_ready[r] - now) : 0;
    endfunction

    function automatic bit m_hazard(int r, int use_);
        return (r != 0) && m_pend[r] && (m_cnt(r) > use_);
    endfunction

    function automatic bit m_fwd(int r);
        return (r != 0) && m_pend[r] && (m_cnt(r) == 0);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 32; i++) begin
            m_pend[i]  = 1'b0;
            m_ready[i] = 0;
            m_tag[i]   = 0;
        end
        m_next = 0;
    endtask

    task automatic step(input int v, input int rs, input int rsu, input int rt, input int rtu,
                        input int we, input int wa, input int tnew,
                        input int wbv, input int wbwa, input int wbtag,
                        input int fl, input int r);
        exp_t e;
        bit   acc;
        issue_valid  = 1'(v);
        issue_rs     = 5'(rs);
        issue_rs_use = 2'(rsu);
        issue_rt     = 5'(rt);
        issue_rt_use = 2'(rtu);
        issue_we     = 1'(we);
        issue_wa     = 5'(wa);
        issue_tnew   = 2'(tnew);
        wb_valid     = 1'(wbv);
        wb_wa        = 5'(wbwa);
        wb_tag       = 3'(wbtag);
        flush        = 1'(fl);
        rst          = 1'(r);

        e.stall = (v != 0) && (m_hazard(rs, rsu) || m_hazard(rt, rtu));
        e.fr    = m_fwd(rs);
        e.ft    = m_fwd(rt);
        e.tag   = m_next;
        e.cyc   = now;
        expq.push_back(e);
        acc = (v != 0) && !e.stall && (fl == 0);

        @(posedge clk);
        if (r != 0) begin
            m_reset();
        end else if (fl != 0) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else begin
            if (wbv != 0 && wbwa != 0 && m_pend[wbwa] && m_tag[wbwa] == wbtag)
                m_pend[wbwa] = 1'b0;
            if (acc && we != 0 && wa != 0) begin
                m_pend[wa]  = 1'b1;
                m_ready[wa] = now + 1 + tnew;
                m_tag[wa]   = m_next;
            end
            if (acc) m_next = (m_next + 1) % 8;
        end
        now++;
        #1;
    endtask

    task automatic idle_read(input int rs, input int rt);
        step(0, rs, 0, rt, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(negedge clk) begin
        if (expq.size() != 0) begin
            exp_t e;
            e = expq.pop_front();
            n_checks++;
            if (stall === e.stall && fwd_rs === e.fr && fwd_rt === e.ft && int'(issue_tag) == e.tag) begin
                n_pass++;
            end else begin
                $display("FAIL outputs cyc=%0d got stall=%0b fwd_rs=%0b fwd_rt=%0b tag=%0d want stall=%0b fwd_rs=%0b fwd_rt=%0b tag=%0d",
                         e.cyc, stall, fwd_rs, fwd_rt, issue_tag, e.stall, e.fr, e.ft, e.tag);
            end
        end
    end

    initial begin
        int t0;
        int wr;
        int wt;
        rst = 1'b1; issue_valid = 1'b0; issue_rs = '0; issue_rs_use = '0; issue_rt = '0;
        issue_rt_use = '0; issue_we = 1'b0; issue_wa = '0; issue_tnew = '0; wb_valid = 1'b0;
        wb_wa = '0; wb_tag = '0; flush = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state, then write to r5 with two cycles to go; a Tuse=0 reader stalls twice.
        idle_read(5, 7);
        step(1, 0, 3, 0, 3, 1, 5, 2, 0, 0, 0, 0, 0);
        repeat (3) step(1, 5, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);

        // Reader with Tuse=1 against count 1: no stall, forward one cycle later.
        step(1, 0, 3, 0, 3, 1, 8, 1, 0, 0, 0, 0, 0);
        step(1, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 3, 8, 1, 0, 0, 0, 0, 0, 0, 0, 0);

        // Superseded write-back tag must not clear the newer entry.
        t0 = m_next;
        step(1, 0, 3, 0, 3, 1, 3, 0, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 3, 1, 3, 0, 0, 0, 0, 0, 0);
        step(0, 3, 0, 0, 3, 0, 0, 0, 1, 3, t0, 0, 0);
        step(0, 3, 0, 0, 3, 0, 0, 0, 1, 3, (t0 + 1) % 8, 0, 0);
        idle_read(3, 0);

        // Issue and matching write-back on the same register: the issue wins.
        step(1, 0, 3, 0, 3, 1, 4, 3, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 3, 1, 4, 1, 1, 4, m_tag[4], 0, 0);
        idle_read(4, 4);
        idle_read(4, 4);

        // Flush drops all pending entries and holds the tag counter.
        step(1, 0, 3, 0, 3, 1, 10, 3, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 3, 1, 11, 3, 0, 0, 0, 0, 0);
        step(1, 0, 3, 0, 3, 1, 12, 3, 0, 0, 0, 0, 0);
        step(1, 10, 3, 11, 3, 1, 13, 2, 1, 11, m_tag[11], 1, 0);
        step(1, 10, 0, 11, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 12, 0, 13, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Register 0 is never tracked; tag wraps after eight accepts.
        step(1, 0, 3, 0, 3, 1, 0, 3, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (9) step(1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);

        // Mid-operation reset.
        step(1, 0, 3, 0, 3, 1, 6, 3, 0, 0, 0, 0, 0);
        step(1, 6, 0, 0, 3, 1, 7, 2, 0, 0, 0, 0, 1);
        idle_read(6, 7);

        for (int i = 0; i < 3000; i++) begin
            wr = $urandom_range(0, 7);
            wt = ($urandom_range(0, 9) < 6) ? m_tag[wr] : $urandom_range(0, 7);
            step(($urandom_range(0, 9) < 7) ? 1 : 0,
                 $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 3),
                 $urandom_range(0, 1), wr, wt,
                 ($urandom_range(0, 99) < 3) ? 1 : 0,
                 ($urandom_range(0, 499) == 0) ? 1 : 0);
        end

        repeat (2) @(posedge clk);
        #1;
        if (expq.size() != 0) begin
            n_checks++;
            $display("FAIL drain got %0d pending expectations want 0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
